music_player: RTL and testbench

- Downstream of the calculator core stage.
- When the core raises its music-on flag after a result, this block plays one of three short fixed tunes on a square-wave buzzer output.
- Tune selection: neutral, negative, or zero result.
- Signals tune completion back to the core through the music-on handshake.
- Aborts immediately if the core drops the request.

---
 rtl/music_pkg.sv | 55 +++++
 rtl/music_player_if.sv | 20 ++
 rtl/music_tune_rom.sv | 42 ++++
 rtl/music_player.sv | 165 ++++++++++++++++
 tb/tb_music_player.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/music_pkg.sv
// Shared constants for the result-tune player: note codes, 50 MHz half-period
// table, tune indices, FSM state encoding and the ROM entry layout.
package music_pkg;

   localparam logic [3:0] REST  = 4'd0;
   localparam logic [3:0] DO    = 4'd1;
   localparam logic [3:0] RE    = 4'd2;
   localparam logic [3:0] MI    = 4'd3;
   localparam logic [3:0] FA    = 4'd4;
   localparam logic [3:0] SOL   = 4'd5;
   localparam logic [3:0] LA    = 4'd6;
   localparam logic [3:0] SI    = 4'd7;
   localparam logic [3:0] H_DO  = 4'd8;
   localparam logic [3:0] H_RE  = 4'd9;
   localparam logic [3:0] H_MI  = 4'd10;
   localparam logic [3:0] H_FA  = 4'd11;
   localparam logic [3:0] H_SOL = 4'd12;
   localparam logic [3:0] H_LA  = 4'd13;
   localparam logic [3:0] H_SI  = 4'd14;

   // Half-period in 50 MHz cycles; code 15 is unused and clamps to 1.
   localparam logic [17:0] NOTE_HALF [0:15] = '{
      18'd0,     18'd95556, 18'd85131, 18'd75843,
      18'd71586, 18'd63776, 18'd56818, 18'd50620,
      18'd47778, 18'd42566, 18'd37921, 18'd35793,
      18'd31888, 18'd28409, 18'd25310, 18'd0
   };

   localparam logic [1:0] TUNE_OK   = 2'd0;
   localparam logic [1:0] TUNE_NEG  = 2'd1;
   localparam logic [1:0] TUNE_ZERO = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_DONE = 2'd3
   } music_state_e;

   typedef struct packed {
      logic [3:0] note;
      logic [1:0] beats;
   } tune_entry_t;

   function automatic logic [17:0] shifted_half(input logic [3:0] note, input int unsigned shr);
      logic [17:0] v;
      v = NOTE_HALF[note] >> shr;
      if (v == 18'd0) begin
         return 18'd1;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/music_player_if.sv
// Handshake and tone bundle between the calculator core and the music player.
interface music_player_if;
   logic       IN_music_on;
   logic       IN_neg_ans;
   logic       IN_zero;
   logic       OUT_buzzer;
   logic       OUT_music_on;
   logic       OUT_playing;
   logic [3:0] OUT_note;

   modport master (
      output IN_music_on, IN_neg_ans, IN_zero,
      input  OUT_buzzer, OUT_music_on, OUT_playing, OUT_note
   );

   modport slave (
      input  IN_music_on, IN_neg_ans, IN_zero,
      output OUT_buzzer, OUT_music_on, OUT_playing, OUT_note
   );
endinterface

// File: rtl/music_tune_rom.sv
// Combinational tune ROM: three 8-entry tunes of {note, beats}; tune 3 is silent.
module music_tune_rom
   import music_pkg::*;
(
   input  logic [1:0]  tune,
   input  logic [2:0]  idx,
   output tune_entry_t entry
);

   // tune/index lookup, anything unlisted is a one-beat rest
   always_comb begin
      entry = '{REST, 2'd0};
      case ({tune, idx})
         {TUNE_OK,   3'd0}: entry = '{DO,   2'd1};
         {TUNE_OK,   3'd1}: entry = '{MI,   2'd0};
         {TUNE_OK,   3'd2}: entry = '{SOL,  2'd0};
         {TUNE_OK,   3'd3}: entry = '{H_DO, 2'd1};
         {TUNE_OK,   3'd4}: entry = '{SOL,  2'd0};
         {TUNE_OK,   3'd5}: entry = '{H_DO, 2'd0};
         {TUNE_OK,   3'd6}: entry = '{H_MI, 2'd0};
         {TUNE_OK,   3'd7}: entry = '{H_DO, 2'd2};
         {TUNE_NEG,  3'd0}: entry = '{SOL,  2'd1};
         {TUNE_NEG,  3'd1}: entry = '{FA,   2'd0};
         {TUNE_NEG,  3'd2}: entry = '{MI,   2'd0};
         {TUNE_NEG,  3'd3}: entry = '{RE,   2'd0};
         {TUNE_NEG,  3'd4}: entry = '{DO,   2'd1};
         {TUNE_NEG,  3'd5}: entry = '{REST, 2'd0};
         {TUNE_NEG,  3'd6}: entry = '{LA,   2'd0};
         {TUNE_NEG,  3'd7}: entry = '{DO,   2'd2};
         {TUNE_ZERO, 3'd0}: entry = '{MI,   2'd0};
         {TUNE_ZERO, 3'd1}: entry = '{MI,   2'd0};
         {TUNE_ZERO, 3'd2}: entry = '{REST, 2'd0};
         {TUNE_ZERO, 3'd3}: entry = '{MI,   2'd0};
         {TUNE_ZERO, 3'd4}: entry = '{REST, 2'd0};
         {TUNE_ZERO, 3'd5}: entry = '{DO,   2'd0};
         {TUNE_ZERO, 3'd6}: entry = '{MI,   2'd1};
         {TUNE_ZERO, 3'd7}: entry = '{SOL,  2'd3};
         default:           entry = '{REST, 2'd0};
      endcase
   end

endmodule

// File: rtl/music_player.sv
// Plays one of three result tunes on a square-wave buzzer when the core requests it.
// Build option MUSIC_ARTIC_EN silences the last BEAT_CYCLES/8 cycles of every note.
module music_player
   import music_pkg::*;
#(
   parameter int unsigned BEAT_CYCLES = 12_500_000,
   parameter int unsigned TONE_SHR    = 0,
   parameter int unsigned TUNE_LEN    = 8
) (
   input logic           IN_clk,
   input logic           IN_rst_n,
   music_player_if.slave bus
);

   localparam logic [1:0]  S_IDLE   = ST_IDLE;
   localparam logic [1:0]  S_LOAD   = ST_LOAD;
   localparam logic [1:0]  S_PLAY   = ST_PLAY;
   localparam logic [1:0]  S_DONE   = ST_DONE;
   localparam logic [2:0]  LAST_IDX = 3'(TUNE_LEN - 1);
   localparam logic [25:0] BEAT_26  = 26'(BEAT_CYCLES);
`ifdef MUSIC_ARTIC_EN
   localparam logic [25:0] ARTIC_26 = 26'(BEAT_CYCLES / 8);
`endif

   logic [1:0]  state_r;
   logic        req_r;
   logic [1:0]  tune_r;
   logic [2:0]  idx_r;
   logic [3:0]  note_r;
   logic [17:0] half_r;
   logic [17:0] tone_cnt_r;
   logic [25:0] beat_cnt_r;
   logic        buzzer_r;
   logic        music_on_r;
   logic        playing_r;

   tune_entry_t entry_s;
   logic        start_s;
   logic        silence_s;
   logic [1:0]  tune_sel_s;
   logic [17:0] half_load_s;
   logic [25:0] beat_load_s;

   music_tune_rom u_rom (
      .tune  (tune_r),
      .idx   (idx_r),
      .entry (entry_s)
   );

   // start detection, tune priority and per-entry load values
   always_comb begin
      tune_sel_s  = TUNE_OK;
      start_s     = bus.IN_music_on & ~req_r & (state_r == S_IDLE);
      half_load_s = shifted_half(entry_s.note, TONE_SHR);
      beat_load_s = (({24'd0, entry_s.beats} + 26'd1) * BEAT_26) - 26'd1;
      if (bus.IN_zero) begin
         tune_sel_s = TUNE_ZERO;
      end else if (bus.IN_neg_ans) begin
         tune_sel_s = TUNE_NEG;
      end else begin
         tune_sel_s = TUNE_OK;
      end
`ifdef MUSIC_ARTIC_EN
      silence_s = (note_r == REST) || (beat_cnt_r <= ARTIC_26);
`else
      silence_s = (note_r == REST);
`endif
   end

   // sequencer FSM with tone/beat counters and registered outputs
   always_ff @(posedge IN_clk or negedge IN_rst_n) begin
      if (!IN_rst_n) begin
         state_r    <= S_IDLE;
         req_r      <= 1'b0;
         tune_r     <= 2'd0;
         idx_r      <= 3'd0;
         note_r     <= 4'd0;
         half_r     <= 18'd0;
         tone_cnt_r <= 18'd0;
         beat_cnt_r <= 26'd0;
         buzzer_r   <= 1'b0;
         music_on_r <= 1'b1;
         playing_r  <= 1'b0;
      end else begin
         req_r <= bus.IN_music_on;
         case (state_r)
            S_IDLE: begin
               music_on_r <= 1'b1;
               if (start_s) begin
                  tune_r  <= tune_sel_s;
                  idx_r   <= 3'd0;
                  state_r <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (!bus.IN_music_on) begin
                  state_r   <= S_IDLE;
                  buzzer_r  <= 1'b0;
                  playing_r <= 1'b0;
                  note_r    <= 4'd0;
                  idx_r     <= 3'd0;
               end else begin
                  note_r     <= entry_s.note;
                  half_r     <= half_load_s;
                  tone_cnt_r <= half_load_s - 18'd1;
                  beat_cnt_r <= beat_load_s;
                  playing_r  <= 1'b1;
                  buzzer_r   <= 1'b0;
                  state_r    <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (!bus.IN_music_on) begin
                  state_r   <= S_IDLE;
                  buzzer_r  <= 1'b0;
                  playing_r <= 1'b0;
                  note_r    <= 4'd0;
                  idx_r     <= 3'd0;
               end else if (beat_cnt_r == 26'd0) begin
                  buzzer_r <= 1'b0;
                  if (idx_r == LAST_IDX) begin
                     state_r    <= S_DONE;
                     music_on_r <= 1'b0;
                     playing_r  <= 1'b0;
                     note_r     <= 4'd0;
                     idx_r      <= 3'd0;
                  end else begin
                     idx_r   <= idx_r + 3'd1;
                     state_r <= S_LOAD;
                  end
               end else begin
                  beat_cnt_r <= beat_cnt_r - 26'd1;
                  // silence also freezes the tone counter so rests cost nothing
                  if (silence_s) begin
                     buzzer_r <= 1'b0;
                  end else if (tone_cnt_r == 18'd0) begin
                     tone_cnt_r <= half_r - 18'd1;
                     buzzer_r   <= ~buzzer_r;
                  end else begin
                     tone_cnt_r <= tone_cnt_r - 18'd1;
                  end
               end
            end
            S_DONE: begin
               music_on_r <= 1'b1;
               state_r    <= S_IDLE;
            end
            default: begin
               state_r    <= S_IDLE;
               buzzer_r   <= 1'b0;
               playing_r  <= 1'b0;
               note_r     <= 4'd0;
               idx_r      <= 3'd0;
               music_on_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.OUT_buzzer   = buzzer_r;
   assign bus.OUT_music_on = music_on_r;
   assign bus.OUT_playing  = playing_r;
   assign bus.OUT_note     = note_r;

endmodule

// File: tb/tb_music_player.sv
// Randomized bench for music_player against a per-cycle tune model built from
// note/beat tables; honours MUSIC_ARTIC_EN when the build defines it.
module tb_music_player;

   localparam int BEAT = 64;
   localparam int SHR  = 10;
   localparam logic [6:0] IDLE_OBS = 7'h40;

   logic IN_clk = 1'b0;
   logic IN_rst_n;
   int   n_checks;
   int   n_errors;
   logic [6:0] exp_q[$];

   int half_tab [16] = '{0, 95556, 85131, 75843, 71586, 63776, 56818, 50620,
                         47778, 42566, 37921, 35793, 31888, 28409, 25310, 0};
   int tune_notes [3][8] = '{'{1, 3, 5, 8, 5, 8, 10, 8},
                             '{5, 4, 3, 2, 1, 0, 6, 1},
                             '{3, 3, 0, 3, 0, 1, 3, 5}};
   int tune_beats [3][8] = '{'{1, 0, 0, 1, 0, 0, 0, 2},
                             '{1, 0, 0, 0, 1, 0, 0, 2},
                             '{0, 0, 0, 0, 0, 0, 1, 3}};

   music_player_if bus ();

   music_player #(
      .BEAT_CYCLES (BEAT),
      .TONE_SHR    (SHR),
      .TUNE_LEN    (8)
   ) dut (
      .IN_clk   (IN_clk),
      .IN_rst_n (IN_rst_n),
      .bus      (bus)
   );

   always #5 IN_clk = ~IN_clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] obs();
      return {bus.OUT_music_on, bus.OUT_playing, bus.OUT_buzzer, bus.OUT_note};
   endfunction

   // square wave starting low, toggling every half-period; rests and articulation gap silent
   function automatic logic model_buzz(input int nt, input int p, input int len);
      int h;
      if (nt == 0) return 1'b0;
`ifdef MUSIC_ARTIC_EN
      if (p >= len - BEAT / 8) return 1'b0;
`endif
      h = half_tab[nt] >> SHR;
      if (h < 1) h = 1;
      return 1'((p / h) % 2);
   endfunction

   // expected {music_on, playing, buzzer, note} per cycle, from the first LOAD to DONE
   function automatic void build_expected(input int t);
      logic [3:0] prev_note;
      logic       prev_play;
      int         nt;
      int         len;
      exp_q.delete();
      prev_note = 4'd0;
      prev_play = 1'b0;
      for (int k = 0; k < 8; k++) begin
         nt  = tune_notes[t][k];
         len = (tune_beats[t][k] + 1) * BEAT;
         exp_q.push_back({1'b1, prev_play, 1'b0, prev_note});
         for (int p = 0; p < len; p++)
            exp_q.push_back({1'b1, 1'b1, model_buzz(nt, p, len), 4'(nt)});
         prev_note = 4'(nt);
         prev_play = 1'b1;
      end
      exp_q.push_back(7'h00);
   endfunction

   task automatic run_tune(input logic z, input logic ng, input bit do_abort, input bit directed);
      int t;
      int total;
      int acc;
      int abort_at;
      int low_cnt;
      int low_at;
      int first_rise;
      t = z ? 2 : (ng ? 1 : 0);
      build_expected(t);
      total = 8;
      for (int k = 0; k < 8; k++) total += (tune_beats[t][k] + 1) * BEAT;
      acc = 0;
      for (int k = 0; k < 3; k++) acc += (tune_beats[t][k] + 1) * BEAT + 1;
      abort_at = do_abort ? acc + int'($urandom_range(0, (tune_beats[t][3] + 1) * BEAT)) : -1;
      low_cnt = 0;
      low_at = -1;
      first_rise = -1;
      @(negedge IN_clk);
      bus.IN_zero = z;
      bus.IN_neg_ans = ng;
      bus.IN_music_on = 1'b1;
      for (int c = 0; c < exp_q.size(); c++) begin
         @(negedge IN_clk);
         chk("cycle", obs(), exp_q[c]);
         if (!bus.OUT_music_on) begin
            low_cnt++;
            low_at = c;
         end
         if (bus.OUT_buzzer && first_rise < 0) first_rise = c;
         bus.IN_zero = 1'($urandom);
         bus.IN_neg_ans = 1'($urandom);
         if (c == abort_at) begin
            bus.IN_music_on = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge IN_clk);
               chk("abort_idle", obs(), IDLE_OBS);
            end
            chk("abort_no_ack", low_cnt, 0);
            return;
         end
      end
      chk("ack_count", low_cnt, 1);
      chk("ack_at", low_at, total);
      if (directed) chk("first_rise", first_rise, 1 + (half_tab[1] >> SHR));
      for (int i = 0; i < 10; i++) begin
         @(negedge IN_clk);
         chk("hold_no_restart", obs(), IDLE_OBS);
      end
      bus.IN_music_on = 1'b0;
      @(negedge IN_clk);
      chk("idle", obs(), IDLE_OBS);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      IN_rst_n = 1'b0;
      bus.IN_music_on = 1'b0;
      bus.IN_zero = 1'b0;
      bus.IN_neg_ans = 1'b0;
      repeat (3) @(negedge IN_clk);
      chk("reset", obs(), IDLE_OBS);
      IN_rst_n = 1'b1;
      @(negedge IN_clk);
      chk("idle", obs(), IDLE_OBS);

      run_tune(1'b0, 1'b0, 1'b0, 1'b1);
      run_tune(1'b1, 1'b1, 1'b0, 1'b0);
      run_tune(1'b0, 1'b1, 1'b0, 1'b0);
      run_tune(1'b0, 1'b0, 1'b1, 1'b0);
      run_tune(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         run_tune(1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      // asynchronous reset in the middle of the first note, while the buzzer is high
      build_expected(0);
      @(negedge IN_clk);
      bus.IN_zero = 1'b0;
      bus.IN_neg_ans = 1'b0;
      bus.IN_music_on = 1'b1;
      for (int c = 0; c <= 101; c++) begin
         @(negedge IN_clk);
         chk("pre_reset", obs(), exp_q[c]);
      end
      #2 IN_rst_n = 1'b0;
      #1 chk("async_reset", obs(), IDLE_OBS);
      bus.IN_music_on = 1'b0;
      @(negedge IN_clk);
      IN_rst_n = 1'b1;
      @(negedge IN_clk);
      chk("post_reset", obs(), IDLE_OBS);
      run_tune(1'b1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
